// File: rtl/sixteen_bit_serializer.sv
// LSB-first 16-bit parallel-to-serial converter with valid/ready handshakes on
// both sides and a one-cycle completion pulse.
module sixteen_bit_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        sout,
  output logic        sout_valid,
  input  logic        sout_ready,
  output logic        last,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sreg_q, sreg_d;
  logic [3:0]  cnt_q, cnt_d;

  logic in_ready_q;
  logic sout_q;
  logic sout_valid_q;
  logic last_q;
  logic done_q;
  logic busy_q;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sout_ready) begin
          sreg_d = {1'b0, sreg_q[15:1]};
          // Counter parks at 15 on the final bit instead of wrapping.
          if (cnt_q == 4'd15) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= (state_d == IDLE);
      sout_q       <= (state_d == SHIFT) & sreg_d[0];
      sout_valid_q <= (state_d == SHIFT);
      last_q       <= (state_d == SHIFT) && (cnt_d == 4'd15);
      done_q       <= (state_d == DONE);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign in_ready   = in_ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign last       = last_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sixteen_bit_serializer.sv
// Bench for sixteen_bit_serializer: phase-count model plus word scoreboard,
// with directed scenarios pinned by literal expectations.
module tb_sixteen_bit_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in = '0;
  logic        in_valid = 1'b0;
  logic        sout_ready = 1'b0;
  logic        in_ready, sout, sout_valid, last, done, busy;

  sixteen_bit_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .last       (last),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: phase 0 = waiting for a word, 1..16 = presenting bit phase-1, 17 = completion.
  int          phase = 0;
  logic [15:0] mword = '0;
  logic [15:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 0;
      mword <= '0;
      exp_q.delete();
    end else if (phase == 0) begin
      if (in_valid) begin
        phase <= 1;
        mword <= in;
        exp_q.push_back(in);
      end
    end else if (phase <= 16) begin
      if (sout_ready) phase <= phase + 1;
    end else begin
      phase <= 0;
    end
  end

  logic [15:0] rx = '0;
  int          nb = 0;
  int          sb_words = 0;

  always @(negedge clk) begin
    chk("in_ready", in_ready, phase == 0);
    chk("busy", busy, phase != 0);
    chk("sout_valid", sout_valid, (phase >= 1) && (phase <= 16));
    chk("last", last, phase == 16);
    chk("done", done, phase == 17);
    if ((phase >= 1) && (phase <= 16)) chk("sout", sout, mword[phase-1]);
    if (rst) begin
      chk("sout_in_reset", sout, 0);
      nb = 0;
    end else if (sout_valid && sout_ready) begin
      rx[nb] = sout;
      nb++;
      if (nb == 16) begin
        nb = 0;
        sb_words++;
        chk("sb_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("sb_word", rx, exp_q.pop_front());
      end
    end
  end

  int cyc = 0;
  bit obs_bits[$];
  int obs_last_idx[$];
  int done_cyc[$];
  int acc_cyc[$];
  int obs_done = 0;
  int obs_xfer = 0;
  int tot_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (sout_valid) begin
        if (last) obs_last_idx.push_back(obs_bits.size());
        obs_bits.push_back(sout);
        if (sout_ready) obs_xfer++;
      end
      if (done) begin
        obs_done++;
        tot_done++;
        done_cyc.push_back(cyc);
      end
      if (in_ready && in_valid) acc_cyc.push_back(cyc + 1);
    end
  end

  task automatic clear_obs();
    obs_bits.delete();
    obs_last_idx.delete();
    done_cyc.delete();
    acc_cyc.delete();
    obs_done = 0;
    obs_xfer = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_dones(input int target, input int limit, input string name);
    int n = 0;
    while (obs_done < target && n < limit) begin
      step();
      n++;
    end
    chk(name, obs_done >= target, 1);
  endtask

  task automatic count_bits(input int lo, input int hi, output int ones, output int zeros);
    ones = 0;
    zeros = 0;
    for (int i = lo; i < hi && i < obs_bits.size(); i++) begin
      if (obs_bits[i]) ones++;
      else zeros++;
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t1e[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    int ones, zeros, n, base_words;

    // Reset with in_valid asserted: outputs idle, nothing captured.
    #1 rst = 1'b1;
    in_valid = 1'b1;
    in = 16'hBEEF;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sout", sout, 0);
    chk("rst_sout_valid", sout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", last, 0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_capture_busy", busy, 0);

    // Basic A5C3 transfer.
    clear_obs();
    step();
    in = 16'hA5C3;
    in_valid = 1'b1;
    sout_ready = 1'b1;
    step();
    in_valid = 1'b0;
    wait_dones(1, 40, "t1_done_timeout");
    chk("t1_nbits", obs_bits.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("t1_bit%0d", i), obs_bits[i], t1e[i]);
    chk("t1_last_count", obs_last_idx.size(), 1);
    chk("t1_last_pos", obs_last_idx[0], 15);
    chk("t1_latency", done_cyc[0] - acc_cyc[0], 16);

    // Stall after first bit of 0001.
    clear_obs();
    step();
    in = 16'h0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    sout_ready = 1'b0;
    repeat (5) @(posedge clk);
    #2 sout_ready = 1'b1;
    wait_dones(1, 40, "t2_done_timeout");
    count_bits(0, obs_bits.size(), ones, zeros);
    chk("t2_ones_held", ones, 6);
    chk("t2_zeros", zeros, 15);
    chk("t2_done_count", obs_done, 1);

    // in_valid with FFFF while shifting 0000 is ignored until idle.
    clear_obs();
    step();
    in = 16'h0000;
    in_valid = 1'b1;
    step();
    in = 16'hFFFF;
    wait_dones(1, 40, "t3_done1_timeout");
    step();
    in_valid = 1'b0;
    wait_dones(2, 40, "t3_done2_timeout");
    chk("t3_nbits", obs_bits.size(), 32);
    count_bits(0, 16, ones, zeros);
    chk("t3_first_zeros", zeros, 16);
    count_bits(16, 32, ones, zeros);
    chk("t3_second_ones", ones, 16);

    // Asynchronous reset after the 7th bit of 1234.
    clear_obs();
    step();
    in = 16'h1234;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (obs_xfer < 7 && n < 40) begin
      step();
      n++;
    end
    chk("t4_xfer7", obs_xfer, 7);
    rst = 1'b1;
    #1;
    chk("t4_async_sout_valid", sout_valid, 0);
    chk("t4_async_busy", busy, 0);
    chk("t4_async_in_ready", in_ready, 1);
    chk("t4_async_sout", sout, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) step();
    chk("t4_no_done", obs_done, 0);
    clear_obs();
    in = 16'h00FF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_dones(1, 40, "t4_done_timeout");
    count_bits(0, 8, ones, zeros);
    chk("t4_low_ones", ones, 8);
    count_bits(8, 16, ones, zeros);
    chk("t4_high_zeros", zeros, 8);
    chk("t4_nbits", obs_bits.size(), 16);

    // Back-to-back FFFF then 0000 with in_valid held.
    clear_obs();
    step();
    in = 16'hFFFF;
    in_valid = 1'b1;
    step();
    in = 16'h0000;
    wait_dones(1, 40, "t5_done1_timeout");
    step();
    in_valid = 1'b0;
    wait_dones(2, 40, "t5_done2_timeout");
    count_bits(0, 16, ones, zeros);
    chk("t5_first_ones", ones, 16);
    count_bits(16, 32, ones, zeros);
    chk("t5_second_zeros", zeros, 16);
    chk("t5_accepts", acc_cyc.size(), 2);
    chk("t5_gap", acc_cyc[1] - done_cyc[0], 2);
    chk("t5_total_cycles", done_cyc[1] - acc_cyc[0] + 1, 35);

    // Random words with random downstream stalls.
    base_words = sb_words;
    n = 0;
    while ((sb_words - base_words) < 1000 && n < 60000) begin
      step();
      sout_ready = ($urandom_range(0, 3) != 0);
      in_valid = 1'($urandom_range(0, 1));
      in = 16'($urandom);
      n++;
    end
    in_valid = 1'b0;
    sout_ready = 1'b1;
    repeat (24) step();
    chk("t6_words", sb_words - base_words >= 1000, 1);
    chk("done_per_word", tot_done, sb_words);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sixteen_bit_serializer.md
SIXTEEN_BIT_SERIALIZER -- requirements
Module: sixteen_bit_serializer

Interface
REQ-001 The block SHALL have a single clock domain and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset; takes effect immediately, independent of clk.
REQ-004 in  input  16  parallel word to be serialized.
REQ-005 in_valid  input  1  upstream asserts when in holds a word to send.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 sout  output  1  current serial bit.
REQ-008 sout_valid  output  1  sout holds a valid bit.
REQ-009 sout_ready  input  1  downstream accepts sout this cycle; may stall indefinitely.
REQ-010 last  output  1  sout is bit 15 of the current word.
REQ-011 done  output  1  one-cycle pulse after bit 15 is accepted.
REQ-012 busy  output  1  high in SHIFT and DONE states.

Function
REQ-013 The block SHALL implement three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: in_ready=1, sout_valid=0, busy=0.
REQ-015 IDLE, in_valid=1 at a clk edge: capture in into a 16-bit shift register, clear the 4-bit bit counter to 0, enter SHIFT.
REQ-016 In IDLE, in_valid=0 SHALL leave all state unchanged.
REQ-017 SHIFT: in_ready=0, sout_valid=1, sout=shift register bit 0 (LSB-first).
REQ-018 In SHIFT, in_valid SHALL be ignored and in SHALL NOT be sampled.
REQ-019 SHIFT, sout_ready=1 at a clk edge: shift register shifts right by one (MSB filled with 0), counter increments by 1.
REQ-020 SHIFT, sout_ready=0: shift register, counter and sout SHALL hold (stall).
REQ-021 last SHALL be 1 exactly when state=SHIFT and counter=15.
REQ-022 SHIFT, counter=15, sout_ready=1: enter DONE; the counter SHALL NOT wrap into a 17th bit.
REQ-023 DONE: lasts exactly one cycle with done=1, sout_valid=0, in_ready=0; then IDLE.
REQ-024 done SHALL be 0 in every state other than DONE.
REQ-025 Latency: word accepted at edge N; first bit valid in the cycle after edge N; with sout_ready held at 1, done is high in the cycle after edge N+16, and in_ready is high again after edge N+17.
REQ-026 Exactly 16 bits SHALL be transferred per accepted word, in order in[0]..in[15].

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, shift register=16'h0000, counter=0.
REQ-028 While rst=1: sout=0, sout_valid=0, last=0, done=0, busy=0, in_ready=1.
REQ-029 Reset asserted during SHIFT or DONE SHALL abort the word with no done pulse; after release the block accepts a new word on the first edge where in_valid=1.
REQ-030 in_valid asserted together with rst SHALL NOT be captured.

Verification
REQ-031 Basic: in=16'hA5C3, one-cycle in_valid, sout_ready=1 -> sout sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; last only on the 16th bit; done one cycle later.
REQ-032 Stall: in=16'h0001, sout_ready=0 for 5 cycles after the first bit -> sout=1 held with sout_valid=1 for 6 cycles, then 15 zeros, done pulse.
REQ-033 Busy ignore: in_valid=1 with in=16'hFFFF during SHIFT of 16'h0000 -> all 16 bits sent are 0; 16'hFFFF is accepted only after the return to IDLE.
REQ-034 Mid-word reset: rst pulsed asynchronously after the 7th bit of 16'h1234 -> sout_valid drops at once, no done pulse; 16'h00FF sent next serializes as eight 1s then eight 0s.
REQ-035 Back-to-back: in_valid held at 1 with 16'hFFFF then 16'h0000, sout_ready=1 -> 16 ones, a one-cycle DONE gap, one IDLE accept cycle, then 16 zeros; total 35 cycles from the first accept to the second done.
REQ-036 Random: 1000 random words with random sout_ready -> the scoreboard reconstructs every word exactly; exactly one done pulse per word.
